// File: rtl/alu_xor_driver.sv
// Operand driver and result collector for the adiabatic XOR datapath.
// Buffers operand pairs, sequences the four power clocks and captures Cout with a mismatch flag.
module alu_xor_driver #(
    parameter int WIDTH      = 16,
    parameter int PHASE_CYC  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_cout,
    output logic             clkpos1,
    output logic             clkneg1,
    output logic             clkpos2,
    output logic             clkneg2,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_mismatch
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(PHASE_CYC);
    localparam logic [CW-1:0] PHASE_LAST = CW'(PHASE_CYC - 1);
    localparam logic [AW:0]   DEPTH_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        EVAL1,
        EVAL2,
        REC1,
        REC2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [WIDTH-1:0] r_memA [FIFO_DEPTH];
    logic [WIDTH-1:0] r_memB [FIFO_DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             r_opReady;

    logic [CW-1:0]    r_phase;
    logic [WIDTH-1:0] r_aluA;
    logic [WIDTH-1:0] r_aluB;
    logic             r_clkPos1;
    logic             r_clkPos2;
    logic             r_clkNeg1;
    logic             r_clkNeg2;
    logic             r_resValid;
    logic [WIDTH-1:0] r_resData;
    logic             r_resMismatch;

    logic             w_push;
    logic             w_pop;
    logic             w_capture;
    logic             w_empty;
    logic             w_lastPhase;
    logic [AW:0]      w_countNext;
    logic [CW-1:0]    w_phaseNext;
    logic             w_pos1Next;
    logic             w_pos2Next;

    assign w_push      = op_valid && r_opReady;
    assign w_empty     = (r_count == '0);
    assign w_lastPhase = (r_phase == PHASE_LAST);
    assign w_countNext = r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);

    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_nextState = EVAL1;
                    w_pop       = 1'b1;
                end
            end
            EVAL1: begin
                if (w_lastPhase) w_nextState = EVAL2;
            end
            EVAL2: begin
                // Hold the evaluation phase until the previous result has been taken.
                if (w_lastPhase && (!r_resValid || res_ready)) begin
                    w_nextState = REC1;
                    w_capture   = 1'b1;
                end
            end
            REC1: begin
                if (w_lastPhase) w_nextState = REC2;
            end
            REC2: begin
                if (w_lastPhase) begin
                    if (!w_empty) begin
                        w_nextState = EVAL1;
                        w_pop       = 1'b1;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_phaseNext = r_phase;
        if (w_nextState != r_state) begin
            w_phaseNext = '0;
        end else if (!w_lastPhase) begin
            w_phaseNext = r_phase + CW'(1);
        end
    end

    assign w_pos1Next = (w_nextState == EVAL1) || (w_nextState == EVAL2);
    assign w_pos2Next = (w_nextState == EVAL2) || (w_nextState == REC1);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memA[r_wrPtr] <= op_a;
            r_memB[r_wrPtr] <= op_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_opReady <= 1'b1;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
            r_count   <= w_countNext;
            r_opReady <= (w_countNext != DEPTH_CNT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_phase   <= '0;
            r_aluA    <= '0;
            r_aluB    <= '0;
            r_clkPos1 <= 1'b0;
            r_clkPos2 <= 1'b0;
            r_clkNeg1 <= 1'b1;
            r_clkNeg2 <= 1'b1;
        end else begin
            r_state   <= w_nextState;
            r_phase   <= w_phaseNext;
            r_clkPos1 <= w_pos1Next;
            r_clkPos2 <= w_pos2Next;
            r_clkNeg1 <= !w_pos1Next;
            r_clkNeg2 <= !w_pos2Next;
            if (w_pop) begin
                r_aluA <= r_memA[r_rdPtr];
                r_aluB <= r_memB[r_rdPtr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resValid    <= 1'b0;
            r_resData     <= '0;
            r_resMismatch <= 1'b0;
        end else begin
            if (w_capture) begin
                r_resValid    <= 1'b1;
                r_resData     <= alu_cout;
                r_resMismatch <= (alu_cout != (r_aluA ^ r_aluB));
            end else if (res_ready) begin
                r_resValid <= 1'b0;
            end
        end
    end

    assign op_ready     = r_opReady;
    assign alu_a        = r_aluA;
    assign alu_b        = r_aluB;
    assign clkpos1      = r_clkPos1;
    assign clkpos2      = r_clkPos2;
    assign clkneg1      = r_clkNeg1;
    assign clkneg2      = r_clkNeg2;
    assign res_valid    = r_resValid;
    assign res_data     = r_resData;
    assign res_mismatch = r_resMismatch;

endmodule

// File: tb/tb_alu_xor_driver.sv
// Directed bench for alu_xor_driver; the XOR array is modelled as A^B with an optional bit-flip mask.
// Cycle n below means the negedge following the n-th rising edge after the first operand push.
module tb_alu_xor_driver;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_cout;
    logic        clkpos1;
    logic        clkneg1;
    logic        clkpos2;
    logic        clkneg2;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_mismatch;

    logic [15:0] flipMask;
    logic        monEn;
    int          testsRun;
    int          failCount;

    alu_xor_driver #(
        .WIDTH(16),
        .PHASE_CYC(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .op_a(op_a),
        .op_b(op_b),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_cout(alu_cout),
        .clkpos1(clkpos1),
        .clkneg1(clkneg1),
        .clkpos2(clkpos2),
        .clkneg2(clkneg2),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_mismatch(res_mismatch)
    );

    assign alu_cout = alu_a ^ alu_b ^ flipMask;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
    endtask

    // Power-clock pairs must be complementary on every sampled cycle.
    always @(negedge clk) begin
        if (monEn) begin
            checkOutput("pair1_complement", 32'(clkpos1 ^ clkneg1), 32'd1);
            checkOutput("pair2_complement", 32'(clkpos2 ^ clkneg2), 32'd1);
        end
    end

    logic [15:0] opA  [6];
    logic [15:0] opB  [6];
    logic [15:0] expX [6];
    int          idx;
    logic        willPush;
    logic        sawValid;
    logic        sawPos1;

    initial begin
        testsRun  = 0;
        failCount = 0;
        monEn     = 1'b0;
        rst_n     = 1'b0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b1;
        flipMask  = '0;
        opA  = '{16'h1234, 16'hFFFF, 16'h8000, 16'hAAAA, 16'h0000, 16'h1357};
        opB  = '{16'h00FF, 16'h0F0F, 16'h0001, 16'h5555, 16'h0000, 16'h2468};
        expX = '{16'h12CB, 16'hF0F0, 16'h8001, 16'hFFFF, 16'h0000, 16'h373F};

        // Reset state
        repeat (3) @(negedge clk);
        monEn = 1'b1;
        checkOutput("rst_pos1", 32'(clkpos1), 32'd0);
        checkOutput("rst_neg1", 32'(clkneg1), 32'd1);
        checkOutput("rst_pos2", 32'(clkpos2), 32'd0);
        checkOutput("rst_neg2", 32'(clkneg2), 32'd1);
        checkOutput("rst_alu_a", 32'(alu_a), 32'd0);
        checkOutput("rst_alu_b", 32'(alu_b), 32'd0);
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_res_data", 32'(res_data), 32'd0);
        checkOutput("rst_res_mismatch", 32'(res_mismatch), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_op_ready", 32'(op_ready), 32'd1);

        // Single op latency and phase sequence
        applyStimulus(16'hA5A5, 16'h0FF0);
        @(negedge clk);
        op_valid = 1'b0;
        checkOutput("t1_pos1_n0", 32'(clkpos1), 32'd0);
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            if (n == 1) begin
                checkOutput("t1_pos1_n1", 32'(clkpos1), 32'd1);
                checkOutput("t1_pos2_n1", 32'(clkpos2), 32'd0);
                checkOutput("t1_alu_a", 32'(alu_a), 32'h0000A5A5);
                checkOutput("t1_alu_b", 32'(alu_b), 32'h00000FF0);
            end
            if (n == 4) checkOutput("t1_pos2_n4", 32'(clkpos2), 32'd0);
            if (n == 5) begin
                checkOutput("t1_pos1_n5", 32'(clkpos1), 32'd1);
                checkOutput("t1_pos2_n5", 32'(clkpos2), 32'd1);
            end
            if (n == 8) checkOutput("t1_valid_n8", 32'(res_valid), 32'd0);
            if (n == 9) begin
                checkOutput("t1_valid_n9", 32'(res_valid), 32'd1);
                checkOutput("t1_data", 32'(res_data), 32'h0000AA55);
                checkOutput("t1_mismatch", 32'(res_mismatch), 32'd0);
                checkOutput("t1_pos1_n9", 32'(clkpos1), 32'd0);
                checkOutput("t1_pos2_n9", 32'(clkpos2), 32'd1);
            end
            if (n == 10) checkOutput("t1_valid_n10", 32'(res_valid), 32'd0);
            if (n == 13) checkOutput("t1_pos2_n13", 32'(clkpos2), 32'd0);
            if (n == 17) begin
                checkOutput("t1_pos1_n17", 32'(clkpos1), 32'd0);
                checkOutput("t1_alu_a_held", 32'(alu_a), 32'h0000A5A5);
            end
        end

        // Mismatch: bit 3 of Cout flipped
        flipMask = 16'h0008;
        applyStimulus(16'hFFFF, 16'h0000);
        @(negedge clk);
        op_valid = 1'b0;
        checkOutput("t3_pos1_n0", 32'(clkpos1), 32'd0);
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            if (n == 1) checkOutput("t3_pos1_n1", 32'(clkpos1), 32'd1);
            if (n == 9) begin
                checkOutput("t3_valid", 32'(res_valid), 32'd1);
                checkOutput("t3_data", 32'(res_data), 32'h0000FFF7);
                checkOutput("t3_mismatch", 32'(res_mismatch), 32'd1);
            end
        end
        flipMask = 16'h0000;

        // Six ops back-to-back through a four-entry FIFO
        idx = 0;
        applyStimulus(opA[0], opB[0]);
        willPush = op_ready;
        for (int n = 0; n <= 100; n++) begin
            @(negedge clk);
            if (willPush) idx++;
            if (idx < 6) applyStimulus(opA[idx], opB[idx]);
            else op_valid = 1'b0;
            if (n == 3)  checkOutput("t2_ready_n3", 32'(op_ready), 32'd1);
            if (n == 4)  checkOutput("t2_ready_n4", 32'(op_ready), 32'd0);
            if (n == 16) checkOutput("t2_ready_n16", 32'(op_ready), 32'd0);
            if (n == 17) begin
                checkOutput("t2_ready_n17", 32'(op_ready), 32'd1);
                checkOutput("t2_pos1_n17", 32'(clkpos1), 32'd1);
            end
            for (int k = 0; k < 6; k++) begin
                if (n == 8 + 16 * k) checkOutput($sformatf("t2_idle_valid_%0d", k), 32'(res_valid), 32'd0);
                if (n == 9 + 16 * k) begin
                    checkOutput($sformatf("t2_valid_%0d", k), 32'(res_valid), 32'd1);
                    checkOutput($sformatf("t2_data_%0d", k), 32'(res_data), 32'(expX[k]));
                    checkOutput($sformatf("t2_mismatch_%0d", k), 32'(res_mismatch), 32'd0);
                end
            end
            willPush = op_valid && op_ready;
        end
        checkOutput("t2_push_count", 32'(idx), 32'd6);

        // Stall in EVAL2 while the previous result is unconsumed
        res_ready = 1'b0;
        applyStimulus(16'h0001, 16'h0002);
        @(negedge clk);
        applyStimulus(16'h00F0, 16'h000F);
        @(negedge clk);
        op_valid = 1'b0;
        for (int n = 2; n <= 30; n++) begin
            @(negedge clk);
            if (n == 9) begin
                checkOutput("t4_valid_n9", 32'(res_valid), 32'd1);
                checkOutput("t4_data_n9", 32'(res_data), 32'h00000003);
            end
            if (n == 17) checkOutput("t4_alu_a_n17", 32'(alu_a), 32'h000000F0);
            if (n == 25 || n == 30) begin
                checkOutput("t4_stall_pos1", 32'(clkpos1), 32'd1);
                checkOutput("t4_stall_pos2", 32'(clkpos2), 32'd1);
                checkOutput("t4_stall_alu_a", 32'(alu_a), 32'h000000F0);
                checkOutput("t4_stall_data", 32'(res_data), 32'h00000003);
                checkOutput("t4_stall_valid", 32'(res_valid), 32'd1);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        checkOutput("t4_cap_valid", 32'(res_valid), 32'd1);
        checkOutput("t4_cap_data", 32'(res_data), 32'h000000FF);
        checkOutput("t4_cap_mismatch", 32'(res_mismatch), 32'd0);
        checkOutput("t4_cap_pos1", 32'(clkpos1), 32'd0);
        checkOutput("t4_cap_pos2", 32'(clkpos2), 32'd1);
        @(negedge clk);
        checkOutput("t4_drained", 32'(res_valid), 32'd0);
        repeat (10) @(negedge clk);

        // Asynchronous reset in EVAL2 with two ops queued
        applyStimulus(16'h0101, 16'h1010);
        @(negedge clk);
        applyStimulus(16'h2222, 16'h0202);
        @(negedge clk);
        applyStimulus(16'h3333, 16'h0303);
        @(negedge clk);
        op_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("t5_pre_pos2", 32'(clkpos2), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_pos1", 32'(clkpos1), 32'd0);
        checkOutput("t5_neg1", 32'(clkneg1), 32'd1);
        checkOutput("t5_pos2", 32'(clkpos2), 32'd0);
        checkOutput("t5_neg2", 32'(clkneg2), 32'd1);
        checkOutput("t5_valid", 32'(res_valid), 32'd0);
        checkOutput("t5_data", 32'(res_data), 32'd0);
        checkOutput("t5_alu_a", 32'(alu_a), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        sawValid = 1'b0;
        sawPos1  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            sawValid = sawValid | res_valid;
            sawPos1  = sawPos1 | clkpos1;
        end
        checkOutput("t5_no_result", 32'(sawValid), 32'd0);
        checkOutput("t5_no_eval", 32'(sawPos1), 32'd0);
        checkOutput("t5_op_ready", 32'(op_ready), 32'd1);

        monEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/alu_xor_driver.md
Name: alu_xor_driver

Overview:
- Operand-side driver and result collector for the 16-bit adiabatic XOR datapath.
- Accepts operand pairs over a valid/ready interface and buffers them in a small FIFO.
- Generates the four adiabatic phase clocks from one system clock, presents A/B stable across the full power-clock cycle, and captures Cout at the end of evaluation.
- Returns each result over valid/ready with a mismatch flag against the expected A^B. It is used by the ALU verification bench and by the top-level operand issue path.

Parameters:
WIDTH, 16, operand/result width
PHASE_CYC, 4, system-clock cycles per adiabatic phase (>=2)
FIFO_DEPTH, 4, operand FIFO entries (power of 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
op_valid  input  1  operand pair valid
op_ready  output  1  operand FIFO not full
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
alu_a  output  WIDTH  A driven to XOR array
alu_b  output  WIDTH  B driven to XOR array
alu_cout  input  WIDTH  Cout from XOR array
clkpos1  output  1  phase-1 power clock
clkneg1  output  1  complement of clkpos1
clkpos2  output  1  phase-2 power clock
clkneg2  output  1  complement of clkpos2
res_valid  output  1  result valid
res_ready  input  1  result consumer ready
res_data  output  WIDTH  captured Cout
res_mismatch  output  1  res_data != alu_a^alu_b at capture

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n. All outputs are registered.
- Reset values, applied immediately on rst_n low, including mid-operation:
  - FSM goes to IDLE; FIFO is emptied and the in-flight op is discarded.
  - clkpos1 = clkpos2 = 0; clkneg1 = clkneg2 = 1.
  - alu_a = alu_b = 0; res_valid = 0; res_data = 0; res_mismatch = 0.
  - op_ready = 1 once rst_n is high.
- Operand FIFO:
  - op_ready = !full.
  - A push occurs on op_valid && op_ready.
  - Push and pop in the same cycle are allowed when full; op_ready still reflects pre-pop fullness.
  - Order is strictly FIFO.
- FSM states: IDLE, EVAL1, EVAL2, REC1, REC2. Each non-IDLE state lasts PHASE_CYC cycles, counted by a phase counter that resets on every state entry.
- Phase clock levels by state:
  - IDLE: clkpos1 = 0, clkpos2 = 0.
  - EVAL1: clkpos1 = 1, clkpos2 = 0.
  - EVAL2: clkpos1 = 1, clkpos2 = 1.
  - REC1: clkpos1 = 0, clkpos2 = 1.
  - REC2: clkpos1 = 0, clkpos2 = 0.
  - clkneg1 = !clkpos1 and clkneg2 = !clkpos2 at all times, with no overlap cycle.
- IDLE -> EVAL1 when the FIFO is non-empty: pop the head and load alu_a/alu_b on the same edge.
- alu_a/alu_b hold stable from EVAL1 entry until the next pop. They retain their value in IDLE.
- EVAL1 -> EVAL2 after PHASE_CYC cycles.
- EVAL2 exit on its last cycle:
  - If !res_valid || res_ready, capture alu_cout into res_data, set res_mismatch = (alu_cout != (alu_a ^ alu_b)), set res_valid = 1, and go to REC1.
  - Otherwise stall in EVAL2 with the counter held at its terminal value and the clocks held high; stall length is unbounded.
- REC1 -> REC2 after PHASE_CYC cycles.
- REC2 last cycle: if the FIFO is non-empty, pop and go directly to EVAL1 (back-to-back); else go to IDLE.
- Result handshake:
  - res_valid clears on res_valid && res_ready unless a new capture happens on the same edge; in that case res_valid stays 1 with the new data.
  - res_data/res_mismatch are stable while res_valid && !res_ready.
- Latency: op accepted at edge E0 into an idle, empty block -> EVAL1 at E0+1 -> res_valid high after edge E0+2*PHASE_CYC+1 (9 cycles at default).
- Sustained throughput: one op per 4*PHASE_CYC cycles (16 at default).

Test Plan:
- Reset then a single op, A=16'hA5A5, B=16'h0FF0, with the model returning A^B -> clkpos1 rises at cycle 1 and clkpos2 at cycle 5; res_valid at cycle 9 with res_data=16'hAA55, res_mismatch=0; IDLE reached at cycle 17.
- 6 ops pushed back-to-back, with res_ready=1 and FIFO_DEPTH=4 -> op_ready drops while the FIFO holds 4 entries; results come out in order, 16 cycles apart, with no IDLE cycle between ops.
- Model forces alu_cout bit 3 flipped on A=16'hFFFF, B=16'h0000 -> res_data=16'hFFF7, res_mismatch=1.
- res_ready=0 while one result is pending and a second op is reaching the end of EVAL2 -> FSM stalls in EVAL2 with clkpos1=clkpos2=1 and alu_a held; after res_ready=1 for one cycle, the second result is captured on that edge.
- rst_n pulsed low during EVAL2 with 2 ops queued -> clocks return to pos=0/neg=1 asynchronously; FIFO empty, res_valid=0, no result emitted after release.
- Check across all tests -> clkneg1/clkneg2 are never equal to clkpos1/clkpos2 on any cycle.
